fft2d_row_feeder: RTL
=====================

# fft2d_row_feeder

Frame buffer and row sequencer sitting directly upstream of `fft_2d`. Accepts one 32×32 complex SFP frame through a single-sample write port, then on command streams it row by row into `fft_2d` in that block's 4-lane interleaved order. It drives a `start_i` pulse followed by 256 contiguous beats, so the FFT core's input contract is met without any testbench-side sequencing.

## Interface
Parameters:
- `NB`, 12: SFP word width in bits, equal to the codebase `nb`.
- `ROWS`, 32: rows per frame.
- `COLS`, 32: complex points per row.
- `LANES`, 4: samples per beat. `COLS/LANES` = 8 beats per row.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `wr_en_i`  in  1  write strobe for one complex sample.
- `wr_row_i`  in  5  row index of the write.
- `wr_col_i`  in  5  column index of the write.
- `wr_re_i`  in  NB  real part.
- `wr_im_i`  in  NB  imaginary part.
- `go_i`  in  1  request to stream the frame; sampled only when `busy_o`=0.
- `busy_o`  out  1  high from the START state through the DONE state.
- `start_o`  out  1  one-cycle pulse; connects to `fft_2d.start_i`.
- `dr_o`  out  LANES×NB  real lanes; connects to `fft_2d.dr_i`.
- `di_o`  out  LANES×NB  imaginary lanes; connects to `fft_2d.di_i`.
- `valid_o`  out  1  high on each of the 256 data beats.
- `done_o`  out  1  one-cycle pulse after the last beat.
- `wr_drop_o`  out  1  one-cycle pulse when a write is discarded.

## Operation
- Storage: `ROWS×COLS` real and `ROWS×COLS` imaginary words. A write stores at [`wr_row_i`][`wr_col_i`] on the clock edge.
- FSM states:
  - IDLE: `go_i`=1 goes to START.
  - START: one cycle, `start_o`=1, then STREAM.
  - STREAM: 256 cycles, then DONE.
  - DONE: one cycle, `done_o`=1, then IDLE.
- Counters:
  - `beat` counts 0..7 and wraps; `row` increments when `beat` wraps.
  - Both are cleared in START.
- Beat (`row`=r, `beat`=c) lane packing. Lane 3 is the MSB slice.
  - `dr_o` = {re[r][c], re[r][c+8], re[r][c+16], re[r][c+24]}.
  - `di_o` = the same pattern taken from im.
- `dr_o`, `di_o` are 0 whenever `valid_o`=0.
- Writes in IDLE are always accepted.
- Writes while `busy_o`=1 are discarded and `wr_drop_o` pulses. Exception: `FEEDER_PINGPONG_EN`, see Configuration.
- `go_i` while `busy_o`=1 is ignored. It is not queued.
- Reset at any time, including mid-stream:
  - FSM returns to IDLE, all outputs go to 0, counters are cleared.
  - Buffer contents are undefined after reset.

## Timing
- Reset values: `busy_o`=0, `start_o`=0, `valid_o`=0, `done_o`=0, `wr_drop_o`=0, `dr_o`=0, `di_o`=0.
- All outputs are registered.
- Latency from `go_i` sampled high at edge E0:
  - `start_o` is high in the cycle after E0.
  - Beat 0 (row 0, c=0) is presented after E1.
  - The last beat (row 31, c=7) is presented after E256.
  - `done_o` is high after E257.
  - `busy_o` is high from after E0 until E258.
- Beats are back-to-back with no bubbles. There is no backpressure.
- A write and a same-cycle stream read of the same address:
  - The pre-write value is streamed.
  - This case only arises with `FEEDER_PINGPONG_EN` disabled? No: it cannot occur in single-bank mode, because such writes are dropped.
- `go_i` asserted in the DONE cycle is ignored. `go_i` is next accepted at the first edge where `busy_o`=0.

## Configuration
- `FEEDER_PINGPONG_EN` defined:
  - Two banks: write bank `wb` and read bank `rb`. At reset `wb`=0 and `rb`=1.
  - An accepted `go_i` sets `rb`←`wb` and toggles `wb` on the same edge.
  - Writes always target `wb` and are accepted in any state, so `wr_drop_o` is tied to 0.
  - A new frame can therefore be loaded during streaming.
- `FEEDER_PINGPONG_EN` not defined:
  - Single bank. Writes while busy are dropped with `wr_drop_o`.

## Test plan
- Load re[r][c]=r·32+c, im=0x800+r·32+c, then pulse `go_i`.
  - `start_o` one cycle later.
  - Beat 0: `dr_o`={0x000,0x008,0x010,0x018}, `di_o`={0x800,0x808,0x810,0x818}.
  - Beat 255: `dr_o`={0x3E7,0x3EF,0x3F7,0x3FF}.
  - `done_o` at E257.
- Count `valid_o`: exactly 256 contiguous cycles. `dr_o`/`di_o`=0 outside them.
- Pulse `go_i` at beat 100 → no effect. Pulse `go_i` in the DONE cycle → ignored. Pulse `go_i` the next cycle → new START.
- Single-bank: write (0,0)=0xABC during STREAM.
  - `wr_drop_o` pulses.
  - The next stream still shows the old value at row 0, lane 3, beat 0.
- Pingpong: stream frame A while writing frame B (all re=0x111).
  - Frame A streams intact.
  - The second `go_i` streams 0x111 in all `dr_o` lanes.
- Deassert `rst_ni` at beat 50 → all outputs 0 immediately and state is IDLE. After release, `go_i` produces a full 256-beat stream.

Source files
------------

// File: rtl/fft2d_row_feeder.sv
// fft2d_row_feeder
// Frame buffer and row sequencer in front of fft_2d. A 32x32 complex frame is
// loaded one sample at a time through the write port; go_i then replays it row
// by row as a start_o pulse followed by 256 back-to-back 4-lane beats.
//
// Optional feature: define FEEDER_PINGPONG_EN for a two-bank buffer so the next
// frame can be written while the current one streams (wr_drop_o is then 0).
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   wr_en_i/wr_row_i/wr_col_i  sample write strobe and address
//   wr_re_i/wr_im_i            sample real/imaginary word
//   go_i                       stream request, honoured only while idle
//   busy_o                     high from START through DONE
//   start_o                    one-cycle pulse ahead of the first beat
//   dr_o/di_o                  LANES x NB real/imag lanes, lane 3 in the MSBs
//   valid_o                    high on each data beat
//   done_o                     one-cycle pulse after the last beat
//   wr_drop_o                  one-cycle pulse for a discarded write
module fft2d_row_feeder #(
    parameter int unsigned NB    = 12,
    parameter int unsigned ROWS  = 32,
    parameter int unsigned COLS  = 32,
    parameter int unsigned LANES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en_i,
    input  logic [$clog2(ROWS)-1:0]   wr_row_i,
    input  logic [$clog2(COLS)-1:0]   wr_col_i,
    input  logic [NB-1:0]             wr_re_i,
    input  logic [NB-1:0]             wr_im_i,
    input  logic                      go_i,
    output logic                      busy_o,
    output logic                      start_o,
    output logic [LANES*NB-1:0]       dr_o,
    output logic [LANES*NB-1:0]       di_o,
    output logic                      valid_o,
    output logic                      done_o,
    output logic                      wr_drop_o
);

    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CW  = $clog2(COLS);
    localparam int unsigned BPR = COLS / LANES;
    localparam int unsigned BW  = $clog2(BPR);
`ifdef FEEDER_PINGPONG_EN
    localparam int unsigned BANKS = 2;
`else
    localparam int unsigned BANKS = 1;
`endif
    localparam int unsigned DEPTH = BANKS * ROWS * COLS;
    localparam int unsigned AW    = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          state, state_d;
    logic [RW-1:0]       row, row_d;
    logic [BW-1:0]       beat, beat_d;
    logic                busy_d, start_d, valid_d, done_d, drop_d;
    logic [LANES*NB-1:0] dr_d, di_d;
    logic                go_accept;
    logic                wr_ok;
    logic [AW-1:0]       wr_addr;
    logic [CW-1:0]       rd_col;
    logic [AW-1:0]       rd_addr;

    logic [NB-1:0] mem_re [DEPTH];
    logic [NB-1:0] mem_im [DEPTH];

`ifdef FEEDER_PINGPONG_EN
    logic wb, rb;

    // Bank swap: the freshly written bank becomes the read bank on go.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb <= 1'b0;
            rb <= 1'b1;
        end else if (go_accept) begin
            rb <= wb;
            wb <= ~wb;
        end
    end

    assign wr_ok   = wr_en_i;
    assign wr_addr = {wb, wr_row_i, wr_col_i};
`else
    assign wr_ok   = wr_en_i && (state == S_IDLE);
    assign wr_addr = {wr_row_i, wr_col_i};
`endif

    // Buffer storage; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_re[wr_addr] <= wr_re_i;
            mem_im[wr_addr] <= wr_im_i;
        end
    end

    // Next state, beat counters and next output values.
    always_comb begin
        state_d   = state;
        row_d     = row;
        beat_d    = beat;
        busy_d    = 1'b0;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        go_accept = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go_i) begin
                    state_d   = S_START;
                    busy_d    = 1'b1;
                    start_d   = 1'b1;
                    row_d     = '0;
                    beat_d    = '0;
                    go_accept = 1'b1;
                end
            end
            S_START: begin
                // Counters name the beat being presented; beat 0 goes out next.
                state_d = S_STREAM;
                busy_d  = 1'b1;
                valid_d = 1'b1;
                row_d   = '0;
                beat_d  = '0;
            end
            S_STREAM: begin
                busy_d = 1'b1;
                if (row == RW'(ROWS - 1) && beat == BW'(BPR - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    row_d   = '0;
                    beat_d  = '0;
                end else begin
                    valid_d = 1'b1;
                    if (beat == BW'(BPR - 1)) begin
                        beat_d = '0;
                        row_d  = row + 1'b1;
                    end else begin
                        beat_d = beat + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FEEDER_PINGPONG_EN
        drop_d = 1'b0;
`else
        drop_d = wr_en_i && (state != S_IDLE);
`endif
    end

    // Lane gather for the beat about to be presented; lane 3 takes column c.
    always_comb begin
        dr_d    = '0;
        di_d    = '0;
        rd_col  = '0;
        rd_addr = '0;
        if (valid_d) begin
            for (int k = 0; k < LANES; k++) begin
                rd_col = CW'(beat_d) + CW'((LANES - 1 - k) * BPR);
`ifdef FEEDER_PINGPONG_EN
                rd_addr = {rb, row_d, rd_col};
`else
                rd_addr = {row_d, rd_col};
`endif
                dr_d[k*NB +: NB] = mem_re[rd_addr];
                di_d[k*NB +: NB] = mem_im[rd_addr];
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            row       <= '0;
            beat      <= '0;
            busy_o    <= 1'b0;
            start_o   <= 1'b0;
            valid_o   <= 1'b0;
            done_o    <= 1'b0;
            wr_drop_o <= 1'b0;
            dr_o      <= '0;
            di_o      <= '0;
        end else begin
            state     <= state_d;
            row       <= row_d;
            beat      <= beat_d;
            busy_o    <= busy_d;
            start_o   <= start_d;
            valid_o   <= valid_d;
            done_o    <= done_d;
            wr_drop_o <= drop_d;
            dr_o      <= dr_d;
            di_o      <= di_d;
        end
    end

endmodule
